i2s_sample_fifo: RTL and testbench
==================================

Name: i2s_sample_fifo

Overview:
- Sample buffer directly upstream of the I2S transmitter.
- Accepts 32-bit stereo words {left[31:16], right[15:0]} from the synthesis core over a valid/ready handshake.
- Stores them in a circular FIFO and drives the transmitter's `sound` input.
- Advances one word per transmitter `ready` pulse; includes prefill gating and underrun accounting.

Parameters:
- DEPTH_LOG2, 4: FIFO holds 2**DEPTH_LOG2 words (default 16).
- START_LEVEL, 8: occupancy required before playback starts or resumes; 1..2**DEPTH_LOG2.
- UNDERRUN_HOLD, 0: sample driven on an unserved request. 0 = drive 32'h0 (silence); 1 = repeat the last `sound` value.

Ports:
- clkin  input  1  system/MCK-domain clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  32  sample word from producer.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept a word this cycle.
- req  input  1  one-cycle sample request; connects to transmitter `ready`.
- sound  output  32  registered sample; connects to transmitter `sound`.
- level  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- running  output  1  1 in RUNNING state.
- underrun_cnt  output  16  saturating count of unserved requests while RUNNING.
- clr_stats  input  1  synchronous clear of underrun_cnt.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr = 0, rd_ptr = 0, level = 0, sound = 0, underrun_cnt = 0, state = FILLING.
  - RAM contents are don't-care.
  - in_ready is 0 while rst is high.
- in_ready = !rst && (level != 2**DEPTH_LOG2). It is combinational from registered level only, never from req.
- Push: in_valid && in_ready at an edge. The word is written at wr_ptr; wr_ptr increments mod depth.
- States:
  - FILLING:
    - req causes no pop.
    - sound <= 0, or holds its value when UNDERRUN_HOLD=1.
    - underrun_cnt is not incremented.
    - Go to RUNNING at the edge where the updated level >= START_LEVEL.
    - The first pop occurs on the next req after entering RUNNING.
  - RUNNING, req with level != 0:
    - sound <= RAM[rd_ptr]; rd_ptr increments mod depth.
    - Latency: sound is valid the cycle after req. The transmitter samples it 127+ cycles later.
  - RUNNING, req with level == 0 (underrun):
    - No pop; sound <= 0, or held when UNDERRUN_HOLD=1.
    - underrun_cnt <= underrun_cnt+1, saturating at 16'hFFFF.
    - state <= FILLING.
- level update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full: the push is refused (in_ready already 0); the pop proceeds.
  - When empty in RUNNING: treated as underrun, no bypass; the pushed word is stored (level becomes 1).
- req while rst high is ignored.
- clr_stats and an underrun in the same cycle: clear wins, so underrun_cnt = 0.
- Pointer wrap: pointers are DEPTH_LOG2 bits and wrap naturally. Full/empty are derived from level, not pointer compare.
- Data order is strictly FIFO. No word is dropped or duplicated except the defined UNDERRUN_HOLD repeat.
- req pulses are assumed at least 2 cycles apart; back-to-back req must still pop correctly, one word per pulse.
- Reset mid-operation discards all buffered words. The first req after reset yields sound = 0.

Test Plan:
- Reset then 3 req pulses, no pushes -> sound stays 32'h0, running=0, underrun_cnt=0, in_ready=1.
- Push 8 words 32'h00010001..32'h00080008, then req every 256 cycles -> running rises after the 8th push. Successive sound = 0x00010001, 0x00020002, ... in order, each the cycle after req; level decrements 8->0.
- Push 16 words continuously with no req -> in_ready drops after the 16th word. A 17th word held on in_valid is not accepted until one req pops; level = 16 then 15, then 16 again.
- In RUNNING, drain to empty, then issue 1 req:
  - UNDERRUN_HOLD=0 -> sound = 0.
  - UNDERRUN_HOLD=1 -> sound keeps the last word.
  - Both settings -> underrun_cnt=1, running=0. Further reqs do not count until refilled to START_LEVEL.
- Same-cycle push and req with level=16 in RUNNING -> level=15, word popped is the oldest, pushed word refused. Same with level=3 -> level stays 3.
- Force underrun_cnt to 16'hFFFF, cause another underrun -> stays 16'hFFFF. Assert clr_stats together with an underrun -> 0. Assert rst with 5 words buffered -> level=0, sound=0, FILLING.

Source files
------------

// File: rtl/i2s_sample_fifo_if.sv
// Producer-to-FIFO sample handshake plus the transmitter request/sample pair.
interface i2s_sample_fifo_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        req;
  logic [31:0] sound;

  modport master (output in_data, in_valid, req, input in_ready, sound);
  modport slave  (input in_data, in_valid, req, output in_ready, sound);
endinterface

// File: rtl/i2s_sample_fifo.sv
// Circular stereo-sample buffer feeding the I2S transmitter; one word per req, sound
// registered the cycle after req. Playback is gated on a prefill level; underruns are counted.
module i2s_sample_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int START_LEVEL   = 8,
  parameter bit UNDERRUN_HOLD = 1'b0
) (
  input  logic                  clkin,
  input  logic                  rst,
  i2s_sample_fifo_if.slave      bus,
  input  logic                  clr_stats,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  running,
  output logic [15:0]           underrun_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] START_LVL = (DEPTH_LOG2+1)'(START_LEVEL);

  typedef enum logic {FILLING, RUNNING} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  underrun;
  logic [DEPTH_LOG2:0]   level_nxt;

  // Full/empty come from the occupancy counter, never from pointer comparison.
  assign bus.in_ready = !rst && (level != FULL_LVL);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == RUNNING) && bus.req && (level != '0);
  assign underrun     = (state == RUNNING) && bus.req && (level == '0);
  assign running      = (state == RUNNING);

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clkin) begin
    if (push)
      mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      bus.sound    <= '0;
      underrun_cnt <= '0;
      state        <= FILLING;
    end else begin
      level <= level_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        bus.sound <= mem[rd_ptr];
      end else if ((state == FILLING || underrun) && !UNDERRUN_HOLD) begin
        bus.sound <= '0;
      end

      // A clear in the same cycle as an underrun leaves the count at zero.
      if (clr_stats)
        underrun_cnt <= '0;
      else if (underrun && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;

      case (state)
        FILLING: if (level_nxt >= START_LVL) state <= RUNNING;
        RUNNING: if (underrun) state <= FILLING;
        default: state <= FILLING;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Two DUTs (silence and hold-on-underrun) share one stimulus stream and are checked
// against a queue-based model, a directed vector table and hand-written corner sequences.
module tb_i2s_sample_fifo;
  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        clr_stats = 1'b0;
  logic        t_vld = 1'b0;
  logic [31:0] t_dat = '0;
  logic        t_req = 1'b0;

  logic [4:0]  level0, level1;
  logic        running0, running1;
  logic [15:0] cnt0, cnt1;

  i2s_sample_fifo_if bus0 ();
  i2s_sample_fifo_if bus1 ();

  assign bus0.in_data  = t_dat;
  assign bus0.in_valid = t_vld;
  assign bus0.req      = t_req;
  assign bus1.in_data  = t_dat;
  assign bus1.in_valid = t_vld;
  assign bus1.req      = t_req;

  i2s_sample_fifo #(.DEPTH_LOG2(4), .START_LEVEL(8), .UNDERRUN_HOLD(1'b0)) dut0 (
    .clkin(clkin), .rst(rst), .bus(bus0.slave), .clr_stats(clr_stats),
    .level(level0), .running(running0), .underrun_cnt(cnt0));

  i2s_sample_fifo #(.DEPTH_LOG2(4), .START_LEVEL(8), .UNDERRUN_HOLD(1'b1)) dut1 (
    .clkin(clkin), .rst(rst), .bus(bus1.slave), .clr_stats(clr_stats),
    .level(level1), .running(running1), .underrun_cnt(cnt1));

  always #5 clkin = ~clkin;

  int checks = 0;
  int failures = 0;

  // Reference model: a word queue plus a play/fill flag.
  logic [31:0] mq[$];
  bit          m_run = 1'b0;
  logic [31:0] m_snd0 = '0;
  logic [31:0] m_snd1 = '0;
  logic [15:0] m_cnt = '0;

  task automatic model_step();
    bit accept, do_pop, under;
    if (rst) begin
      mq.delete();
      m_run = 1'b0; m_snd0 = '0; m_snd1 = '0; m_cnt = '0;
      return;
    end
    accept = t_vld && (mq.size() != 16);
    do_pop = m_run && t_req && (mq.size() != 0);
    under  = m_run && t_req && (mq.size() == 0);
    if (do_pop) begin
      m_snd0 = mq.pop_front();
      m_snd1 = m_snd0;
    end else if (!m_run || under) begin
      m_snd0 = '0;
    end
    if (clr_stats) m_cnt = '0;
    else if (under && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (accept) mq.push_back(t_dat);
    if (!m_run && mq.size() >= 8) m_run = 1'b1;
    else if (under) m_run = 1'b0;
  endtask

  task automatic tick();
    @(posedge clkin);
    model_step();
    @(negedge clkin);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    logic exp_rdy;
    exp_rdy = !rst && (mq.size() != 16);
    chk("level0", 32'(level0), 32'(mq.size()));
    chk("level1", 32'(level1), 32'(mq.size()));
    chk("running0", 32'(running0), 32'(m_run));
    chk("running1", 32'(running1), 32'(m_run));
    chk("sound0", bus0.sound, m_snd0);
    chk("sound1", bus1.sound, m_snd1);
    chk("cnt0", 32'(cnt0), 32'(m_cnt));
    chk("cnt1", 32'(cnt1), 32'(m_cnt));
    chk("in_ready0", 32'(bus0.in_ready), 32'(exp_rdy));
    chk("in_ready1", 32'(bus1.in_ready), 32'(exp_rdy));
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic q, input logic c);
    rst = r; t_vld = v; t_dat = d; t_req = q; clr_stats = c;
    tick();
    check_model();
  endtask

  task automatic drain_to(input int target);
    for (int i = 0; i < 40 && mq.size() > target; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    logic        rst, vld;
    logic [31:0] dat;
    logic        req, clr;
    int          exp_lvl;
    logic        exp_run;
    logic [31:0] exp_snd;
    logic [15:0] exp_cnt;
    logic        exp_rdy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d, input logic q,
                              input int lvl, input logic run, input logic [31:0] snd, input logic rdy);
    vec_t x;
    x.rst = r; x.vld = v; x.dat = d; x.req = q; x.clr = 1'b0;
    x.exp_lvl = lvl; x.exp_run = run; x.exp_snd = snd; x.exp_cnt = '0; x.exp_rdy = rdy;
    return x;
  endfunction

  initial begin
    vec_t        vt[$];
    logic [31:0] first_w, last_w;

    // Reset, three unserved reqs, 8 pushes, then pops in order.
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    for (int k = 1; k <= 8; k++)
      vt.push_back(mk(0, 1, 32'h0001_0001 * k, 0, k, (k == 8), 0, 1));
    vt.push_back(mk(0, 0, 0, 1, 7, 1, 32'h0001_0001, 1));
    vt.push_back(mk(0, 0, 0, 0, 7, 1, 32'h0001_0001, 1));
    vt.push_back(mk(0, 0, 0, 1, 6, 1, 32'h0002_0002, 1));
    vt.push_back(mk(0, 0, 0, 1, 5, 1, 32'h0003_0003, 1));

    @(negedge clkin);
    foreach (vt[i]) begin
      rst = vt[i].rst; t_vld = vt[i].vld; t_dat = vt[i].dat; t_req = vt[i].req;
      clr_stats = vt[i].clr;
      tick();
      chk($sformatf("vec%0d_level", i), 32'(level0), 32'(vt[i].exp_lvl));
      chk($sformatf("vec%0d_running", i), 32'(running0), 32'(vt[i].exp_run));
      chk($sformatf("vec%0d_sound0", i), bus0.sound, vt[i].exp_snd);
      chk($sformatf("vec%0d_sound1", i), bus1.sound, vt[i].exp_snd);
      chk($sformatf("vec%0d_cnt", i), 32'(cnt0), 32'(vt[i].exp_cnt));
      chk($sformatf("vec%0d_in_ready", i), 32'(bus0.in_ready), 32'(vt[i].exp_rdy));
    end

    // Fill to full, hold a 17th word, pop once while pushing.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    first_w = 32'hA000_0000;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, first_w + i, 1'b0, 1'b0);
    chk("full_level", 32'(level0), 32'd16);
    chk("full_in_ready", 32'(bus0.in_ready), 32'd0);
    step(1'b0, 1'b1, 32'hBEEF_0017, 1'b0, 1'b0);
    chk("held17_level", 32'(level0), 32'd16);
    step(1'b0, 1'b1, 32'hBEEF_0017, 1'b1, 1'b0);
    chk("full_pushpop_level", 32'(level0), 32'd15);
    chk("full_pushpop_sound", bus0.sound, first_w);
    step(1'b0, 1'b1, 32'hBEEF_0017, 1'b0, 1'b0);
    chk("refill_level", 32'(level0), 32'd16);

    // Push+pop at level 3 keeps level, then drain and underrun.
    drain_to(3);
    step(1'b0, 1'b1, 32'hC0DE_0003, 1'b1, 1'b0);
    chk("lvl3_pushpop_level", 32'(level0), 32'd3);
    drain_to(0);
    last_w = m_snd0;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("under_cnt", 32'(cnt0), 32'd1);
    chk("under_running", 32'(running0), 32'd0);
    chk("under_sound_silent", bus0.sound, 32'h0);
    chk("under_sound_hold", bus1.sound, last_w);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("filling_no_count", 32'(cnt1), 32'd1);

    // Saturation, then clear colliding with an underrun.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h5A00_0000 + i, 1'b0, 1'b0);
    drain_to(0);
    force dut0.underrun_cnt = 16'hFFFF;
    force dut1.underrun_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1;
    release dut0.underrun_cnt;
    release dut1.underrun_cnt;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("sat_cnt", 32'(cnt0), 32'h0000_FFFF);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h6B00_0000 + i, 1'b0, 1'b0);
    drain_to(0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("clr_wins_cnt", 32'(cnt0), 32'd0);

    // Reset with 5 buffered words.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h7C00_0000 + i, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("rst5_level", 32'(level0), 32'd0);
    chk("rst5_running", 32'(running0), 32'd0);
    chk("rst5_sound", bus1.sound, 32'h0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_req_sound", bus0.sound, 32'h0);

    // Randomized traffic with phases biased toward filling or draining.
    for (int n = 0; n < 4000; n++) begin
      int vld_pct;
      vld_pct = ((n / 300) % 2 == 0) ? 70 : 15;
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 99) < vld_pct,
           $urandom,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 59) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
